// File: rtl/fifo_rd_packer_pkg.sv
// Shared types for the read-side packer: FSM encoding and lane-counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_rd_packer_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_PUSH  = 2'd2
    } state_t;

    // Smallest w with 2**w >= n; sizes the lane counter.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready holding buffer, head entry drives the output stream.
// Latency: a push into an empty buffer is visible at head_data the next cycle.
// Backpressure: caller must not push while count==2 unless popping the same cycle.
//   rd_clk/rst : clock and synchronous active-high reset
//   push, push_data : write one entry
//   pop        : remove head entry (ignored when empty)
//   count      : occupancy 0..2
//   head_data  : oldest entry
module stream_buf2 #(
    parameter int width = 8
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [width-1:0] head_data
);

    logic [width-1:0] ent0;
    logic [width-1:0] ent1;
    logic             pop_ok;

    assign pop_ok    = pop & (count != 2'd0);
    assign head_data = ent0;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0  <= push_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        ent1  <= push_data;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry goes behind whatever stays.
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rst)
        !(push && (count == 2'd2) && !pop));

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs pack_num narrow FIFO words into one wide word; flush emits a partial word with keep mask.
// Latency: read accepted at t lands at t+1; a word completed at t+1 is valid at t+2 (empty buffer).
// Backpressure: reads are credit-gated on buffer space only; m_ready has no path to rd_en.
//   rd_clk, rst            : clock, synchronous active-high reset
//   fifo_empty, rd_data    : FIFO read side (data valid one cycle after an accepted read)
//   rd_en                  : FIFO read request
//   flush, flush_busy      : partial-word flush request / in progress
//   m_data, m_keep         : packed word and lane-valid mask (lane 0 in the low bits)
//   m_valid, m_ready       : output stream handshake
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int data_width = 8,
    parameter int pack_num   = 4
) (
    input  logic                           rd_clk,
    input  logic                           rst,
    input  logic                           fifo_empty,
    input  logic [data_width-1:0]          rd_data,
    output logic                           rd_en,
    input  logic                           flush,
    output logic                           flush_busy,
    output logic [data_width*pack_num-1:0] m_data,
    output logic [pack_num-1:0]            m_keep,
    output logic                           m_valid,
    input  logic                           m_ready
);

    localparam int out_width = data_width * pack_num;
    localparam int lane_w    = clog2(pack_num);
    localparam logic [lane_w-1:0] last_lane = lane_w'(pack_num - 1);

    state_t                          state;
    state_t                          state_nxt;
    logic                            rd_vld_d;
    logic [lane_w-1:0]               lane_cnt;
    logic [out_width-1:0]            pack_q;
    logic [1:0]                      out_cnt;
    logic                            acc;
    logic                            inflight_word;
    logic                            credit_ok;
    logic                            land_full;
    logic                            part_push;
    logic                            buf_push;
    logic                            pop;
    logic [out_width-1:0]            full_word;
    logic [out_width-1:0]            part_word;
    logic [out_width-1:0]            lane_mask;
    logic [pack_num-1:0]             part_keep;
    logic [out_width+pack_num-1:0]   push_dat;
    logic [out_width+pack_num-1:0]   head_dat;

    assign acc           = rd_en & ~fifo_empty;
    assign inflight_word = rd_vld_d & (lane_cnt == last_lane);
    assign land_full     = inflight_word;
    // Room for the word the in-flight byte may complete plus what is already buffered.
    assign credit_ok     = (out_cnt == 2'd0) | ((out_cnt == 2'd1) & ~inflight_word);
    assign m_valid       = (out_cnt != 2'd0);
    assign pop           = m_valid & m_ready;

    // Partial word: only lanes below lane_cnt hold data of the current word.
    always_comb begin
        part_keep = '0;
        lane_mask = '0;
        for (int i = 0; i < pack_num; i++) begin
            part_keep[i] = (lane_w'(i) < lane_cnt);
            lane_mask[i*data_width +: data_width] = {data_width{lane_w'(i) < lane_cnt}};
        end
    end

    always_comb begin
        full_word = pack_q;
        full_word[out_width-1 -: data_width] = rd_data;
    end

    assign part_word = pack_q & lane_mask;
    assign buf_push  = land_full | part_push;
    assign push_dat  = land_full ? {{pack_num{1'b1}}, full_word} : {part_keep, part_word};

    // FSM: state register
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!rd_vld_d) begin
                    state_nxt = (lane_cnt == '0) ? S_RUN : S_PUSH;
                end
            end
            S_PUSH: begin
                if (part_push) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // FSM: outputs. rd_en is held low during reset so no byte is consumed and dropped.
    always_comb begin
        rd_en      = ~rst & ~fifo_empty & (state == S_RUN) & ~flush & credit_ok;
        flush_busy = (state != S_RUN);
        part_push  = (state == S_PUSH) & ((out_cnt != 2'd2) | pop);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_vld_d <= 1'b0;
            lane_cnt <= '0;
            pack_q   <= '0;
        end else begin
            rd_vld_d <= acc;
            if (part_push) begin
                lane_cnt <= '0;
            end else if (rd_vld_d) begin
                pack_q[lane_cnt*data_width +: data_width] <= rd_data;
                lane_cnt <= (lane_cnt == last_lane) ? '0 : lane_cnt + lane_w'(1);
            end
        end
    end

    stream_buf2 #(
        .width(out_width + pack_num)
    ) u_buf (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (push_dat),
        .pop       (pop),
        .count     (out_cnt),
        .head_data (head_dat)
    );

    assign m_data = head_dat[out_width-1:0];
    assign m_keep = head_dat[out_width +: pack_num];

endmodule
